// File: rtl/mem_ctrl_if.sv
// Bus bundle between a CPU-side client and mem_ctrl, including the byte-wide RAM port.
// Handshake: a request is taken when its *_enable is high while the controller is idle; the
// matching *_finished pulses for exactly one cycle when the access completes.
interface mem_ctrl_if;
   logic        if_enable;
   logic [31:0] if_addr;
   logic        if_finished;
   logic [31:0] if_inst;
   logic        mem_enable;
   logic        mem_rw_sel;
   logic [31:0] mem_addr;
   logic [2:0]  mem_data_len;
   logic [31:0] mem_data_i;
   logic        mem_finished;
   logic [31:0] mem_data_o;
   logic        if_busy;
   logic        mem_busy;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        io_buffer_full;
   logic [2:0]  dbg_state;

   modport slave (
      input  if_enable, if_addr, mem_enable, mem_rw_sel, mem_addr, mem_data_len, mem_data_i,
      input  ram_din, io_buffer_full,
      output if_finished, if_inst, mem_finished, mem_data_o, if_busy, mem_busy,
      output ram_dout, ram_a, ram_wr, dbg_state
   );

   modport master (
      output if_enable, if_addr, mem_enable, mem_rw_sel, mem_addr, mem_data_len, mem_data_i,
      output ram_din, io_buffer_full,
      input  if_finished, if_inst, mem_finished, mem_data_o, if_busy, mem_busy,
      input  ram_dout, ram_a, ram_wr, dbg_state
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: instruction fetch and load/store over an 8-bit RAM port.
// Optional macro IO_WRITE_STALL_EN holds stores to 0x0003xxxx while the UART buffer is full.
module mem_ctrl (
   input logic        clk,
   input logic        rst,
   input logic        rdy,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      IF_READ   = 3'd1,
      MEM_READ  = 3'd2,
      MEM_WRITE = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic [2:0]  len_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] asm_q;
   logic        if_finished_q;
   logic        mem_finished_q;
   logic        if_busy_q;
   logic        mem_busy_q;
   logic [31:0] if_inst_q;
   logic [31:0] mem_data_q;
   logic [31:0] ram_a_q;
   logic [7:0]  ram_dout_q;
   logic        ram_wr_q;

   logic [2:0]  cnt_inc_d;
   logic [2:0]  req_len_d;
   logic [1:0]  byte_idx_d;
   logic [31:0] asm_d;
   logic [31:0] next_a_d;
   logic [7:0]  wbyte_d;
   logic [7:0]  wbyte_next_d;
   logic        wr_more_d;
   logic        stall_d;
   logic        stall_acc_d;

   always_comb begin
      cnt_inc_d    = cnt_q + 3'd1;
      // In read states, ram_din carries byte cnt-1 (one-cycle RAM latency).
      byte_idx_d   = cnt_q[1:0] - 2'd1;
      asm_d        = asm_q;
      asm_d[{byte_idx_d, 3'b000} +: 8] = bus.ram_din;
      next_a_d     = addr_q + {29'd0, cnt_inc_d};
      wbyte_d      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      wbyte_next_d = wdata_q[{cnt_inc_d[1:0], 3'b000} +: 8];
      wr_more_d    = cnt_inc_d < len_q;

      if (bus.mem_rw_sel)
         req_len_d = {1'b0, bus.mem_data_len[1:0]} + 3'd1;
      else if (bus.mem_data_len == 3'd0)
         req_len_d = 3'd1;
      else if (bus.mem_data_len > 3'd4)
         req_len_d = 3'd4;
      else
         req_len_d = bus.mem_data_len;

`ifdef IO_WRITE_STALL_EN
      stall_d     = bus.io_buffer_full && (addr_q[31:16] == 16'h0003);
      stall_acc_d = bus.io_buffer_full && (bus.mem_addr[31:16] == 16'h0003);
`else
      stall_d     = 1'b0;
      stall_acc_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 3'd0;
         len_q          <= 3'd0;
         addr_q         <= 32'd0;
         wdata_q        <= 32'd0;
         asm_q          <= 32'd0;
         if_finished_q  <= 1'b0;
         mem_finished_q <= 1'b0;
         if_busy_q      <= 1'b0;
         mem_busy_q     <= 1'b0;
         if_inst_q      <= 32'd0;
         mem_data_q     <= 32'd0;
         ram_a_q        <= 32'd0;
         ram_dout_q     <= 8'd0;
         ram_wr_q       <= 1'b0;
      end else if (rdy) begin
         case (state_q)
            IDLE: begin
               if (bus.mem_enable) begin
                  addr_q     <= bus.mem_addr;
                  len_q      <= req_len_d;
                  wdata_q    <= bus.mem_data_i;
                  cnt_q      <= 3'd0;
                  asm_q      <= 32'd0;
                  mem_busy_q <= 1'b1;
                  ram_a_q    <= bus.mem_addr;
                  if (bus.mem_rw_sel) begin
                     state_q    <= MEM_WRITE;
                     ram_wr_q   <= !stall_acc_d;
                     ram_dout_q <= stall_acc_d ? 8'd0 : bus.mem_data_i[7:0];
                  end else begin
                     state_q <= MEM_READ;
                  end
               end else if (bus.if_enable) begin
                  addr_q    <= bus.if_addr;
                  len_q     <= 3'd4;
                  cnt_q     <= 3'd0;
                  asm_q     <= 32'd0;
                  if_busy_q <= 1'b1;
                  ram_a_q   <= bus.if_addr;
                  state_q   <= IF_READ;
               end
            end
            IF_READ, MEM_READ: begin
               if (cnt_q != 3'd0)
                  asm_q <= asm_d;
               if (cnt_q == len_q) begin
                  state_q    <= DONE;
                  if_busy_q  <= 1'b0;
                  mem_busy_q <= 1'b0;
                  if (state_q == IF_READ) begin
                     if_inst_q     <= asm_d;
                     if_finished_q <= 1'b1;
                  end else begin
                     mem_data_q     <= asm_d;
                     mem_finished_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
                  if (wr_more_d)
                     ram_a_q <= next_a_d;
               end
            end
            MEM_WRITE: begin
               // ram_wr_q low here means byte cnt is still waiting to be issued.
               if (!ram_wr_q) begin
                  if (!stall_d) begin
                     ram_wr_q   <= 1'b1;
                     ram_dout_q <= wbyte_d;
                  end
               end else if (wr_more_d) begin
                  cnt_q      <= cnt_inc_d;
                  ram_a_q    <= next_a_d;
                  ram_wr_q   <= !stall_d;
                  ram_dout_q <= stall_d ? 8'd0 : wbyte_next_d;
               end else begin
                  ram_wr_q       <= 1'b0;
                  ram_dout_q     <= 8'd0;
                  state_q        <= DONE;
                  mem_busy_q     <= 1'b0;
                  mem_finished_q <= 1'b1;
               end
            end
            DONE: begin
               if_finished_q  <= 1'b0;
               mem_finished_q <= 1'b0;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.if_finished  = if_finished_q;
   assign bus.if_inst      = if_inst_q;
   assign bus.mem_finished = mem_finished_q;
   assign bus.mem_data_o   = mem_data_q;
   assign bus.if_busy      = if_busy_q;
   assign bus.mem_busy     = mem_busy_q;
   assign bus.ram_a        = ram_a_q;
   assign bus.ram_dout     = ram_dout_q;
   // A frozen write cycle must not strobe the RAM.
   assign bus.ram_wr       = ram_wr_q & rdy;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single accesses plus hand-written sequences
// for contention, rdy freeze, reset mid-access and the UART store stall (IO_WRITE_STALL_EN).
module tb_mem_ctrl;

   localparam logic [2:0] ST_IDLE = 3'd0;

   logic clk;
   logic rst;
   logic rdy;
   int   checks;
   int   errors;

   mem_ctrl_if bus ();

   mem_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte RAM, 4 KiB aliased on ram_a[11:0]; shares the rdy enable with the rest of the system.
   logic [7:0] ram_mem [0:4095];
   initial begin
      logic [7:0] rd;
      for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
      ram_mem[12'h100] = 8'h13;
      ram_mem[12'h101] = 8'h05;
      ram_mem[12'h102] = 8'h00;
      ram_mem[12'h103] = 8'h00;
      ram_mem[12'h104] = 8'h11;
      ram_mem[12'h105] = 8'h22;
      ram_mem[12'h106] = 8'h33;
      ram_mem[12'h107] = 8'h44;
      ram_mem[12'h200] = 8'h8F;
      bus.ram_din = 8'h00;
      forever begin
         @(posedge clk);
         if (rdy) begin
            rd = ram_mem[bus.ram_a[11:0]];
            if (bus.ram_wr) ram_mem[bus.ram_a[11:0]] = bus.ram_dout;
            bus.ram_din <= rd;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        fetch;
      logic        rw;
      logic [31:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
      int          k;
      logic [31:0] exp_data;
      int          fin;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic f, input logic rw, input logic [31:0] a,
                               input logic [2:0] len, input logic [31:0] wd, input int k,
                               input logic [31:0] ed, input int fin);
      vec_t v;
      v.name = nm; v.fetch = f; v.rw = rw; v.addr = a; v.len = len;
      v.wdata = wd; v.k = k; v.exp_data = ed; v.fin = fin;
      return v;
   endfunction

   // Entry and exit: just after a rising edge; entry cycle is the accept cycle 0.
   task automatic run_vec(input vec_t v);
      logic        fin_act;
      logic        busy_act;
      logic        other_busy;
      logic [31:0] exp_a;
      logic [7:0]  exp_b;
      bus.if_enable    = v.fetch;
      bus.mem_enable   = !v.fetch;
      bus.if_addr      = v.addr;
      bus.mem_addr     = v.addr;
      bus.mem_rw_sel   = v.rw;
      bus.mem_data_len = v.len;
      bus.mem_data_i   = v.wdata;
      for (int c = 1; c <= v.fin + 1; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            bus.if_enable  = 1'b0;
            bus.mem_enable = 1'b0;
         end
         @(negedge clk);
         fin_act    = v.fetch ? bus.if_finished : bus.mem_finished;
         busy_act   = v.fetch ? bus.if_busy : bus.mem_busy;
         other_busy = v.fetch ? bus.mem_busy : bus.if_busy;
         chk($sformatf("%s c%0d finished", v.name, c), {31'd0, fin_act}, {31'd0, c == v.fin});
         chk($sformatf("%s c%0d busy", v.name, c), {31'd0, busy_act}, {31'd0, c < v.fin});
         chk($sformatf("%s c%0d other_busy", v.name, c), {31'd0, other_busy}, 32'd0);
         if (v.rw && !v.fetch) begin
            if (c <= v.k) begin
               exp_a = v.addr + 32'(c - 1);
               exp_b = v.wdata[8*(c-1) +: 8];
               chk($sformatf("%s c%0d ram_wr", v.name, c), {31'd0, bus.ram_wr}, 32'd1);
               chk($sformatf("%s c%0d ram_a", v.name, c), bus.ram_a, exp_a);
               chk($sformatf("%s c%0d ram_dout", v.name, c), {24'd0, bus.ram_dout}, {24'd0, exp_b});
            end else begin
               chk($sformatf("%s c%0d ram_wr", v.name, c), {31'd0, bus.ram_wr}, 32'd0);
               chk($sformatf("%s c%0d ram_dout", v.name, c), {24'd0, bus.ram_dout}, 32'd0);
            end
         end else begin
            chk($sformatf("%s c%0d ram_wr", v.name, c), {31'd0, bus.ram_wr}, 32'd0);
            if (c == v.fin)
               chk($sformatf("%s data", v.name), v.fetch ? bus.if_inst : bus.mem_data_o, v.exp_data);
         end
      end
      @(posedge clk); #1;
   endtask

   vec_t vecs [13];

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = mk("fetch100", 1'b1, 1'b0, 32'h00000100, 3'd0, 32'h0,        4, 32'h00000513, 6);
      vecs[1]  = mk("ld1_200",  1'b0, 1'b0, 32'h00000200, 3'd1, 32'h0,        1, 32'h0000008F, 3);
      vecs[2]  = mk("ld2_104",  1'b0, 1'b0, 32'h00000104, 3'd2, 32'h0,        2, 32'h00002211, 4);
      vecs[3]  = mk("ld4_104",  1'b0, 1'b0, 32'h00000104, 3'd4, 32'h0,        4, 32'h44332211, 6);
      vecs[4]  = mk("st4_400",  1'b0, 1'b1, 32'h00000400, 3'd3, 32'hDEADBEEF, 4, 32'h0,        5);
      vecs[5]  = mk("st2_408",  1'b0, 1'b1, 32'h00000408, 3'd1, 32'h0000CAFE, 2, 32'h0,        3);
      vecs[6]  = mk("st1_40c",  1'b0, 1'b1, 32'h0000040C, 3'd0, 32'h000000A5, 1, 32'h0,        2);
      vecs[7]  = mk("ld4_400",  1'b0, 1'b0, 32'h00000400, 3'd4, 32'h0,        4, 32'hDEADBEEF, 6);
      vecs[8]  = mk("ld2_408",  1'b0, 1'b0, 32'h00000408, 3'd2, 32'h0,        2, 32'h0000CAFE, 4);
      vecs[9]  = mk("ld1_40c",  1'b0, 1'b0, 32'h0000040C, 3'd1, 32'h0,        1, 32'h000000A5, 3);
      vecs[10] = mk("st4_wrap", 1'b0, 1'b1, 32'hFFFFFFFE, 3'd3, 32'h87654321, 4, 32'h0,        5);
      vecs[11] = mk("ld4_wrap", 1'b0, 1'b0, 32'hFFFFFFFE, 3'd4, 32'h0,        4, 32'h87654321, 6);
      vecs[12] = mk("fetch104", 1'b1, 1'b0, 32'h00000104, 3'd0, 32'h0,        4, 32'h44332211, 6);

      // Reset with rdy low: reset must still win.
      rst = 1'b1;
      rdy = 1'b0;
      bus.if_enable = 1'b0; bus.if_addr = 32'd0;
      bus.mem_enable = 1'b0; bus.mem_rw_sel = 1'b0; bus.mem_addr = 32'd0;
      bus.mem_data_len = 3'd0; bus.mem_data_i = 32'd0; bus.io_buffer_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst if_finished",  {31'd0, bus.if_finished}, 32'd0);
      chk("rst if_inst",      bus.if_inst, 32'd0);
      chk("rst mem_finished", {31'd0, bus.mem_finished}, 32'd0);
      chk("rst mem_data_o",   bus.mem_data_o, 32'd0);
      chk("rst if_busy",      {31'd0, bus.if_busy}, 32'd0);
      chk("rst mem_busy",     {31'd0, bus.mem_busy}, 32'd0);
      chk("rst ram_a",        bus.ram_a, 32'd0);
      chk("rst ram_dout",     {24'd0, bus.ram_dout}, 32'd0);
      chk("rst ram_wr",       {31'd0, bus.ram_wr}, 32'd0);
      chk("rst state",        {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
      @(posedge clk); #1;
      rst = 1'b0;
      rdy = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Contention: load wins, fetch (if_enable held through DONE) starts at cycle 4.
      bus.mem_enable = 1'b1; bus.mem_rw_sel = 1'b0; bus.mem_addr = 32'h200; bus.mem_data_len = 3'd1;
      bus.if_enable = 1'b1; bus.if_addr = 32'h100;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_enable = 1'b0;
         if (c == 5) bus.if_enable = 1'b0;
         @(negedge clk);
         chk($sformatf("cont c%0d mem_finished", c), {31'd0, bus.mem_finished}, {31'd0, c == 3});
         chk($sformatf("cont c%0d mem_busy", c), {31'd0, bus.mem_busy}, {31'd0, c < 3});
         chk($sformatf("cont c%0d if_busy", c), {31'd0, bus.if_busy}, {31'd0, c >= 5 && c < 10});
         chk($sformatf("cont c%0d if_finished", c), {31'd0, bus.if_finished}, {31'd0, c == 10});
         if (c == 3) chk("cont load data", bus.mem_data_o, 32'h0000008F);
         if (c == 10) chk("cont fetch data", bus.if_inst, 32'h00000513);
      end
      @(posedge clk); #1;

      // rdy low for cycles 2-4 of a 2-byte load: finish moves from cycle 4 to cycle 7.
      bus.mem_enable = 1'b1; bus.mem_rw_sel = 1'b0; bus.mem_addr = 32'h104; bus.mem_data_len = 3'd2;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_enable = 1'b0;
         rdy = !(c >= 2 && c <= 4);
         @(negedge clk);
         chk($sformatf("frz_ld c%0d finished", c), {31'd0, bus.mem_finished}, {31'd0, c == 7});
         chk($sformatf("frz_ld c%0d busy", c), {31'd0, bus.mem_busy}, {31'd0, c < 7});
         if (c >= 7) chk($sformatf("frz_ld c%0d data", c), bus.mem_data_o, 32'h00002211);
      end
      @(posedge clk); #1;

      // rdy low in the first write cycle: strobe suppressed, byte re-presented next cycle.
      bus.mem_enable = 1'b1; bus.mem_rw_sel = 1'b1; bus.mem_addr = 32'h410;
      bus.mem_data_len = 3'd1; bus.mem_data_i = 32'h00007766;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_enable = 1'b0;
         rdy = (c != 1);
         @(negedge clk);
         chk($sformatf("frz_st c%0d ram_wr", c), {31'd0, bus.ram_wr}, {31'd0, c == 2 || c == 3});
         chk($sformatf("frz_st c%0d finished", c), {31'd0, bus.mem_finished}, {31'd0, c == 4});
         if (c == 2) chk("frz_st c2 ram_a", bus.ram_a, 32'h410);
         if (c == 3) chk("frz_st c3 ram_a", bus.ram_a, 32'h411);
         if (c == 3) chk("frz_st c3 ram_dout", {24'd0, bus.ram_dout}, 32'h77);
      end
      @(posedge clk); #1;
      run_vec(mk("frz_rb", 1'b0, 1'b0, 32'h410, 3'd2, 32'h0, 2, 32'h00007766, 4));

      // Reset in cycle 2 of a 4-byte store: bytes 0,1 land, the rest never do.
      bus.mem_enable = 1'b1; bus.mem_rw_sel = 1'b1; bus.mem_addr = 32'h420;
      bus.mem_data_len = 3'd3; bus.mem_data_i = 32'h44332211;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_enable = 1'b0;
         rst = (c == 2);
         @(negedge clk);
         if (c <= 2) begin
            chk($sformatf("rstmid c%0d ram_wr", c), {31'd0, bus.ram_wr}, 32'd1);
            chk($sformatf("rstmid c%0d ram_a", c), bus.ram_a, 32'h420 + 32'(c - 1));
         end else begin
            chk($sformatf("rstmid c%0d ram_wr", c), {31'd0, bus.ram_wr}, 32'd0);
            chk($sformatf("rstmid c%0d finished", c), {31'd0, bus.mem_finished}, 32'd0);
            chk($sformatf("rstmid c%0d busy", c), {31'd0, bus.mem_busy}, 32'd0);
            chk($sformatf("rstmid c%0d state", c), {29'd0, bus.dbg_state}, {29'd0, ST_IDLE});
         end
      end
      @(posedge clk); #1;
      run_vec(mk("rstmid_rb", 1'b0, 1'b0, 32'h420, 3'd4, 32'h0, 4, 32'h00002211, 6));

`ifdef IO_WRITE_STALL_EN
      // UART full for cycles 0-3: byte held, written in cycle 5, finished in cycle 6.
      bus.io_buffer_full = 1'b1;
      bus.mem_enable = 1'b1; bus.mem_rw_sel = 1'b1; bus.mem_addr = 32'h00030000;
      bus.mem_data_len = 3'd0; bus.mem_data_i = 32'h0000005A;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.mem_enable = 1'b0;
         if (c == 4) bus.io_buffer_full = 1'b0;
         @(negedge clk);
         chk($sformatf("stall c%0d ram_wr", c), {31'd0, bus.ram_wr}, {31'd0, c == 5});
         chk($sformatf("stall c%0d finished", c), {31'd0, bus.mem_finished}, {31'd0, c == 6});
         if (c == 5) chk("stall c5 ram_a", bus.ram_a, 32'h00030000);
         if (c == 5) chk("stall c5 ram_dout", {24'd0, bus.ram_dout}, 32'h5A);
      end
      @(posedge clk); #1;
`else
      // Without the stall option a full UART buffer changes nothing.
      bus.io_buffer_full = 1'b1;
      run_vec(mk("io_ignored", 1'b0, 1'b1, 32'h00030000, 3'd0, 32'h0000005A, 1, 32'h0, 2));
      bus.io_buffer_full = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
